// File: rtl/bldc_pkg.sv
// bldc_pkg: hall step constants, invalid codes, filter state encoding and adjacency helpers
package bldc_pkg;
  localparam logic [2:0] HALL_S0 = 3'b101;
  localparam logic [2:0] HALL_S1 = 3'b100;
  localparam logic [2:0] HALL_S2 = 3'b110;
  localparam logic [2:0] HALL_S3 = 3'b010;
  localparam logic [2:0] HALL_S4 = 3'b011;
  localparam logic [2:0] HALL_S5 = 3'b001;
  localparam logic [2:0] HALL_INV_LO = 3'b000;
  localparam logic [2:0] HALL_INV_HI = 3'b111;

  typedef enum logic [1:0] {ST_INIT, ST_LOCKED, ST_INVALID} hall_state_t;

  function automatic logic hall_is_invalid(input logic [2:0] c);
    return c == HALL_INV_LO || c == HALL_INV_HI;
  endfunction

  function automatic int hall_idx(input logic [2:0] c);
    return c == HALL_S0 ? 0 : c == HALL_S1 ? 1 : c == HALL_S2 ? 2 :
           c == HALL_S3 ? 3 : c == HALL_S4 ? 4 : 5;
  endfunction

  // Steps are a ring of six, so 001 and 101 are neighbours
  function automatic logic hall_adjacent(input logic [2:0] a, input logic [2:0] b);
    int d;
    d = (hall_idx(a) - hall_idx(b) + 6) % 6;
    return d == 1 || d == 5;
  endfunction
endpackage

// File: rtl/bldc_hall_sync.sv
// bldc_hall_sync: 2-flop synchronizer for the 3 raw hall lines
module bldc_hall_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] i_d,
  output logic [2:0] o_q
);
  logic [2:0] r_meta;
  logic [2:0] r_sync;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end
  assign o_q = r_sync;
endmodule

// File: rtl/bldc_hall_filter.sv
// bldc_hall_filter: debounces hall lines into a qualified code with sticky fault flags
// Skip detection is built only when BLDC_HALL_SKIP_DETECT_EN is defined.
module bldc_hall_filter
  import bldc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] hall_in,
  input  logic       fault_clear,
  output logic [2:0] hall_out,
  output logic       hall_valid,
  output logic       hall_changed,
  output logic       fault_invalid,
  output logic       fault_skip
);
  localparam logic [CNT_WIDTH-1:0] L_SAT = CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] L_ACC = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [2:0]           w_s_hall;
  logic [2:0]           r_prev;
  logic [CNT_WIDTH-1:0] r_cnt;
  hall_state_t          r_state;
  logic [2:0]           r_out;
  logic                 r_changed;
  logic                 r_finv;
  logic                 w_accept;
  logic                 w_legal_acc;
  logic                 w_inv_acc;
  logic                 w_new;

  bldc_hall_sync u_sync (
    .clk  (clk),
    .reset(reset),
    .i_d  (hall_in),
    .o_q  (w_s_hall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= '0;
      r_cnt  <= '0;
    end else begin
      r_prev <= w_s_hall;
      r_cnt  <= (w_s_hall != r_prev) ? '0 : (r_cnt == L_SAT) ? r_cnt : r_cnt + 1'b1;
    end
  end

  // Saturation past L_ACC makes acceptance a single-shot event per stable code
  assign w_accept    = (r_cnt == L_ACC) && (w_s_hall == r_prev);
  assign w_inv_acc   = w_accept && hall_is_invalid(r_prev);
  assign w_legal_acc = w_accept && !hall_is_invalid(r_prev);
  // r_out is 000 until the first legal code, so a nonzero value means a prior legal code exists
  assign w_new       = (r_out != HALL_INV_LO) && (r_prev != r_out);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_INIT;
      r_out     <= '0;
      r_changed <= 1'b0;
      r_finv    <= 1'b0;
    end else begin
      r_changed <= w_legal_acc && w_new;
      r_finv    <= w_inv_acc | (r_finv & ~fault_clear);
      if (w_legal_acc) begin
        r_state <= ST_LOCKED;
        r_out   <= r_prev;
      end else if (w_inv_acc) begin
        r_state <= ST_INVALID;
      end
    end
  end

`ifdef BLDC_HALL_SKIP_DETECT_EN
  logic r_fskip;
  logic w_skip_set;
  assign w_skip_set = w_legal_acc && w_new && !hall_adjacent(r_prev, r_out);
  always_ff @(posedge clk) begin
    if (reset) r_fskip <= 1'b0;
    else r_fskip <= w_skip_set | (r_fskip & ~fault_clear);
  end
  assign fault_skip = r_fskip;
`else
  assign fault_skip = 1'b0;
`endif

  assign hall_out      = r_out;
  assign hall_valid    = (r_state == ST_LOCKED);
  assign hall_changed  = r_changed;
  assign fault_invalid = r_finv;
endmodule
